// File: rtl/serv_rf_ram_bridge.sv
// ============================================================================
// serv_rf_ram_bridge
// Bit-serial register-file ports to W-bit simple dual-port RAM bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serv_rf_ram_bridge #(
    parameter int WIDTH    = 8,
    parameter int CSR_REGS = 4,
    localparam int DEPTH   = 64*32/WIDTH,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wreq,
    input  logic             i_rreq,
    output logic             o_ready,
    input  logic [5:0]       i_wreg0,
    input  logic [5:0]       i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic             i_wdata0,
    input  logic             i_wdata1,
    input  logic [5:0]       i_rreg0,
    input  logic [5:0]       i_rreg1,
    output logic             o_rdata0,
    output logic             o_rdata1,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [WIDTH-1:0] i_rdata
);

    localparam int         L2W        = $clog2(WIDTH);
    localparam logic [4:0] C_GRP_MASK = 5'(WIDTH-1);

    if (!(WIDTH == 2 || WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)
        || CSR_REGS > 32) begin : g_param_check
        $error("serv_rf_ram_bridge: unsupported WIDTH or CSR_REGS");
    end

    function automatic logic [AW-1:0] f_addr(input logic [5:0] rsel, input logic [4:0] cnt);
        return AW'({rsel, cnt} >> L2W);
    endfunction

    // Write side state
    logic             r_wact_q,    w_wact_d;
    logic [4:0]       r_wcnt_q,    w_wcnt_d;
    logic [WIDTH-1:0] r_wsr0_q,    w_wsr0_d;
    logic [WIDTH-1:0] r_wsr1_q,    w_wsr1_d;
    logic [WIDTH-1:0] r_p1_data_q, w_p1_data_d;
    logic [AW-1:0]    r_p1_addr_q, w_p1_addr_d;
    logic             r_p1_en_q,   w_p1_en_d;
    logic             r_p1_pend_q, w_p1_pend_d;
    logic             r_wen_q,     w_wen_d;
    logic [AW-1:0]    r_waddr_q,   w_waddr_d;
    logic [WIDTH-1:0] r_wdata_q,   w_wdata_d;
    // Read side state
    logic             r_ract_q,    w_ract_d;
    logic [5:0]       r_rcnt_q,    w_rcnt_d;
    logic             r_ren0_q,    w_ren0_d;
    logic             r_ren1_q,    w_ren1_d;
    logic [WIDTH-1:0] r_stage_q,   w_stage_d;
    logic [WIDTH-1:0] r_rsr0_q,    w_rsr0_d;
    logic [WIDTH-1:0] r_rsr1_q,    w_rsr1_d;

    logic w_wbound, w_ren, w_rsel1, w_rvalid;

    always_comb begin
        w_wact_d    = r_wact_q;
        w_wcnt_d    = r_wcnt_q;
        w_wsr0_d    = r_wsr0_q;
        w_wsr1_d    = r_wsr1_q;
        w_p1_data_d = r_p1_data_q;
        w_p1_addr_d = r_p1_addr_q;
        w_p1_en_d   = r_p1_en_q;
        w_p1_pend_d = 1'b0;
        w_wen_d     = 1'b0;
        w_waddr_d   = r_waddr_q;
        w_wdata_d   = r_wdata_q;

        // A restart request discards whatever group was in flight.
        w_wbound = r_wact_q && !i_wreq && ((r_wcnt_q & C_GRP_MASK) == C_GRP_MASK);

        if (r_wact_q) begin
            w_wsr0_d = {i_wdata0, r_wsr0_q[WIDTH-1:1]};
            w_wsr1_d = {i_wdata1, r_wsr1_q[WIDTH-1:1]};
        end

        if (r_p1_pend_q) begin
            w_wen_d   = r_p1_en_q;
            w_waddr_d = r_p1_addr_q;
            w_wdata_d = r_p1_data_q;
        end

        if (w_wbound) begin
            w_wen_d     = i_wen0;
            w_waddr_d   = f_addr(i_wreg0, r_wcnt_q);
            w_wdata_d   = {i_wdata0, r_wsr0_q[WIDTH-1:1]};
            w_p1_en_d   = i_wen1;
            w_p1_addr_d = f_addr(i_wreg1, r_wcnt_q);
            w_p1_data_d = {i_wdata1, r_wsr1_q[WIDTH-1:1]};
            w_p1_pend_d = 1'b1;
        end

        if (i_wreq) begin
            w_wact_d = 1'b1;
            w_wcnt_d = 5'd0;
        end else if (r_wact_q) begin
            w_wcnt_d = r_wcnt_q + 5'd1;
            if (r_wcnt_q == 5'd31) begin
                w_wact_d = 1'b0;
            end
        end
    end

    // Read schedule: cycle c of the sequence issues port0/port1 reads at
    // c mod W = 0/1; both shift registers reload together at c mod W = 2.
    assign w_ren    = r_ract_q && (r_rcnt_q < 6'd32) && ((r_rcnt_q[4:0] & C_GRP_MASK) <= 5'd1);
    assign w_rsel1  = r_rcnt_q[0];
    assign w_rvalid = r_ract_q && (r_rcnt_q >= 6'd3);

    always_comb begin
        w_ract_d  = r_ract_q;
        w_rcnt_d  = r_rcnt_q;
        w_ren0_d  = w_ren && !w_rsel1;
        w_ren1_d  = w_ren && w_rsel1;
        w_stage_d = r_ren0_q ? i_rdata : r_stage_q;
        w_rsr0_d  = {1'b0, r_rsr0_q[WIDTH-1:1]};
        w_rsr1_d  = {1'b0, r_rsr1_q[WIDTH-1:1]};

        if (r_ren1_q) begin
            w_rsr0_d = r_stage_q;
            w_rsr1_d = i_rdata;
        end

        if (i_rreq) begin
            w_ract_d = 1'b1;
            w_rcnt_d = 6'd0;
            w_ren0_d = 1'b0;
            w_ren1_d = 1'b0;
        end else if (r_ract_q) begin
            if (r_rcnt_q == 6'd34) begin
                w_ract_d = 1'b0;
                w_rcnt_d = 6'd0;
            end else begin
                w_rcnt_d = r_rcnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wact_q    <= 1'b0;
            r_wcnt_q    <= '0;
            r_wsr0_q    <= '0;
            r_wsr1_q    <= '0;
            r_p1_data_q <= '0;
            r_p1_addr_q <= '0;
            r_p1_en_q   <= 1'b0;
            r_p1_pend_q <= 1'b0;
            r_wen_q     <= 1'b0;
            r_waddr_q   <= '0;
            r_wdata_q   <= '0;
            r_ract_q    <= 1'b0;
            r_rcnt_q    <= '0;
            r_ren0_q    <= 1'b0;
            r_ren1_q    <= 1'b0;
            r_stage_q   <= '0;
            r_rsr0_q    <= '0;
            r_rsr1_q    <= '0;
        end else begin
            r_wact_q    <= w_wact_d;
            r_wcnt_q    <= w_wcnt_d;
            r_wsr0_q    <= w_wsr0_d;
            r_wsr1_q    <= w_wsr1_d;
            r_p1_data_q <= w_p1_data_d;
            r_p1_addr_q <= w_p1_addr_d;
            r_p1_en_q   <= w_p1_en_d;
            r_p1_pend_q <= w_p1_pend_d;
            r_wen_q     <= w_wen_d;
            r_waddr_q   <= w_waddr_d;
            r_wdata_q   <= w_wdata_d;
            r_ract_q    <= w_ract_d;
            r_rcnt_q    <= w_rcnt_d;
            r_ren0_q    <= w_ren0_d;
            r_ren1_q    <= w_ren1_d;
            r_stage_q   <= w_stage_d;
            r_rsr0_q    <= w_rsr0_d;
            r_rsr1_q    <= w_rsr1_d;
        end
    end

    assign o_wen    = r_wen_q;
    assign o_waddr  = r_waddr_q;
    assign o_wdata  = r_wdata_q;
    assign o_ren    = w_ren;
    assign o_raddr  = w_ren ? f_addr(w_rsel1 ? i_rreg1 : i_rreg0, r_rcnt_q[4:0]) : '0;
    assign o_ready  = r_ract_q && (r_rcnt_q == 6'd2);
    // Register x0 always reads as zero.
    assign o_rdata0 = w_rvalid && r_rsr0_q[0] && (i_rreg0 != 6'd0);
    assign o_rdata1 = w_rvalid && r_rsr1_q[0] && (i_rreg1 != 6'd0);

endmodule

`default_nettype wire

// File: doc/serv_rf_ram_bridge.md
Name: serv_rf_ram_bridge

Overview:
- RAM-side counterpart of the core's bit-serial register-file interface.
- Takes two bit-serial write ports (wreg0/wreg1) and two bit-serial read ports (rreg0/rreg1), which address 32 GPRs plus CSR slots with 6-bit addresses.
- Serializes and deserializes those streams into W-bit word accesses on a simple dual-port RAM: one write port, one read port with 1-cycle read latency.
- Sits between the core's register-file interface and the RF RAM macro.

Parameters:
- width, 8, RAM word width W in bits; must be 2, 4, 8, 16 or 32.
- csr_regs, 4, number of CSR slots above the 32 GPRs; must be at most 32.
- depth, 64*32/width, RAM depth in words (derived).
- aw, $clog2(depth), RAM address width (derived); equals 6+5-log2(W).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_wreq  in  1  pulse one cycle before write bit 0.
- i_rreq  in  1  pulse starting a read sequence.
- o_ready  out  1  one-cycle pulse: read bit 0 appears on the next cycle.
- i_wreg0  in  6  write address, port 0.
- i_wreg1  in  6  write address, port 1.
- i_wen0  in  1  write enable, port 0.
- i_wen1  in  1  write enable, port 1.
- i_wdata0  in  1  serial write data, port 0, LSB first.
- i_wdata1  in  1  serial write data, port 1, LSB first.
- i_rreg0  in  6  read address, port 0.
- i_rreg1  in  6  read address, port 1.
- o_rdata0  out  1  serial read data, port 0, LSB first.
- o_rdata1  out  1  serial read data, port 1, LSB first.
- o_waddr  out  aw  RAM write address {reg[5:0], word}.
- o_wdata  out  width  RAM write data.
- o_wen  out  1  RAM write strobe.
- o_raddr  out  aw  RAM read address {reg[5:0], word}.
- o_ren  out  1  RAM read strobe.
- i_rdata  in  width  RAM read data, valid the cycle after o_ren.

Behaviour:
- Reset (async, i_rst=1):
  - All counters, shift registers and active flags clear.
  - o_ready, o_wen, o_ren, o_rdata0 and o_rdata1 are 0.
  - o_waddr, o_raddr and o_wdata are 0.
  - Assertion mid-sequence aborts it immediately; no partial RAM write occurs after reset.
- Word index: bits [4:log2W] of the 5-bit bit counter. Group boundary: counter bits [log2W-1:0] are all ones.
- Write side:
  - i_wreq=1 in cycle T starts the write counter wcnt=0 at T+1; bit k arrives at T+1+k, k=0..31.
  - Each port shifts its data bit into its own W-bit shift register every counting cycle.
  - At a group boundary, if i_wen0 is high in that cycle: o_wen=1 next cycle with o_waddr={i_wreg0,word}, o_wdata=port-0 shift register.
  - Port 1 uses the same rule, with its word held one extra cycle, so it is written one cycle after the port-0 slot. If port 0 is not enabled, port 1 still uses the later slot; timing is fixed.
  - A group whose enable is low at its boundary is not written.
  - After bit 31, write-active clears. The final port-1 write still completes at T+34.
  - i_wreq while write-active restarts wcnt at 0. Any partially collected group is discarded.
- Read side:
  - i_rreq=1 in cycle T sets read-active.
  - T+1: o_ren=1, o_raddr={i_rreg0,0}.
  - T+2: o_ren=1, o_raddr={i_rreg1,0}; i_rdata loads into port-0 shift register.
  - T+3: i_rdata loads into port-1 shift register; o_ready=1.
  - Bit k of both ports is on o_rdata0/o_rdata1 in cycle T+4+k, k=0..31.
  - Each register shifts right every cycle from T+4.
  - Next words are prefetched with the same 2-cycle alternating pattern, so word n+1 loads exactly when word n's last bit has been presented. There are no bubbles.
  - Read-active clears after bit 31 (T+35); o_rdata0/1 return to 0.
  - i_rreq while read-active restarts the sequence from T.
- Register 0: an rreg address of 6'b000000 forces the corresponding o_rdata to 0 regardless of RAM contents.
- Read and write sequences are independent and may overlap, since the RAM is dual-ported. A read of a word being written in the same cycle returns old RAM data; no bypass.
- CSR slots: addresses 32..32+csr_regs-1 are valid. Higher addresses are accepted but are don't-care.

Test Plan:
- Reset mid-read (assert i_rst at T+10 after i_rreq) -> o_rdata0/1, o_ready and o_ren are 0 immediately; no further o_ren after release.
- W=8; i_wreq, then wreg0=5 with data 0xDEADBEEF and wen0=1 for 32 cycles -> four o_wen pulses at T+9, T+17, T+25, T+33, addresses {5,0..3}, data EF, BE, AD, DE.
- Dual write: wreg0=3 gets 0x12345678, wreg1=33 (mtvec slot) gets 0x80000000 -> port-1 writes trail port-0 writes by exactly 1 cycle. RAM readback is exact for both.
- Read rreg0=3, rreg1=33 after the above -> o_ready at T+3; o_rdata0 serializes 0x12345678 and o_rdata1 serializes 0x80000000 LSB first over T+4..T+35, with no gaps.
- Read rreg0=0 with RAM word at reg 0 preloaded to 0xFF -> o_rdata0 is 0 for all 32 bits.
- wen0 dropped during word 2 only -> exactly three writes occur; word 2 of the RAM is unchanged.
